// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS pipeline hazard controller.
// Contents:
//   hz_state_t       - controller FSM states (RUN, DRAIN, HALTED)
//   DRAIN_CYCLES_DEF - default number of cycles needed to empty EX/MEM/WB
//   REG_ZERO         - architectural register $zero (never a real hazard)
//   drain_cnt_bits   - width needed for a drain counter loaded with cycles-1
package mips_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_t;

  localparam int DRAIN_CYCLES_DEF = 3;
  localparam int REG_ZERO         = 0;

  // The counter holds at most cycles-1; keep at least one bit so a
  // single-cycle drain still has a legal vector width.
  function automatic int drain_cnt_bits(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle of pipeline-side signals seen by the hazard controller.
// Inputs to the controller (i_*):
//   i_id_rs, i_id_rt    - source registers of the instruction in ID
//   i_ex_rt             - destination register of the instruction in EX
//   i_ex_mem_read       - EX instruction is a load
//   i_ex_branch_taken   - branch/jump resolved taken in EX
//   i_id_halt           - HALT decoded in ID
//   i_step_mode, i_step - debug single-step enable and advance pulse
// Outputs from the controller (o_*):
//   o_pc_write, o_ifid_write   - PC and IF/ID register enables
//   o_ifid_flush, o_idex_flush - bubble insertion into IF/ID and ID/EX
//   o_pipe_en                  - enable for ID/EX, EX/MEM, MEM/WB
//   o_halted                   - pipeline drained and stopped
//   o_stall_cnt                - saturating load-use stall counter
// modport master: pipeline/testbench side; modport slave: the controller.
interface hazard_ctrl_if #(
  parameter int RBITS   = 5,
  parameter int CNTBITS = 16
);

  logic [RBITS-1:0]   i_id_rs;
  logic [RBITS-1:0]   i_id_rt;
  logic [RBITS-1:0]   i_ex_rt;
  logic               i_ex_mem_read;
  logic               i_ex_branch_taken;
  logic               i_id_halt;
  logic               i_step_mode;
  logic               i_step;
  logic               o_pc_write;
  logic               o_ifid_write;
  logic               o_ifid_flush;
  logic               o_idex_flush;
  logic               o_pipe_en;
  logic               o_halted;
  logic [CNTBITS-1:0] o_stall_cnt;

  modport master (
    output i_id_rs, i_id_rt, i_ex_rt, i_ex_mem_read, i_ex_branch_taken,
           i_id_halt, i_step_mode, i_step,
    input  o_pc_write, o_ifid_write, o_ifid_flush, o_idex_flush, o_pipe_en,
           o_halted, o_stall_cnt
  );

  modport slave (
    input  i_id_rs, i_id_rt, i_ex_rt, i_ex_mem_read, i_ex_branch_taken,
           i_id_halt, i_step_mode, i_step,
    output o_pc_write, o_ifid_write, o_ifid_flush, o_idex_flush, o_pipe_en,
           o_halted, o_stall_cnt
  );

endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use hazard comparator.
// Ports:
//   ex_mem_read - EX instruction is a load
//   ex_rt       - load destination register in EX
//   id_rs/id_rt - source registers of the instruction in ID
//   load_use    - ID instruction needs the load result before it exists
module hazard_detect
  import mips_pkg::*;
#(
  parameter int RBITS = 5
) (
  input  logic             ex_mem_read,
  input  logic [RBITS-1:0] ex_rt,
  input  logic [RBITS-1:0] id_rs,
  input  logic [RBITS-1:0] id_rt,
  output logic             load_use
);

  // A load into $zero writes nothing, so it can never feed a consumer.
  always_comb begin
    load_use = ex_mem_read
             && (ex_rt != RBITS'(REG_ZERO))
             && ((ex_rt == id_rs) || (ex_rt == id_rt));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard, HALT-drain and single-step controller.
// Ports:
//   i_clk   - single clock, all state on the rising edge
//   i_rst_n - asynchronous active-low reset
//   bus     - hazard_ctrl_if.slave carrying ID/EX hazard inputs, debug
//             step controls, and the pipeline enable/flush outputs
// Parameters: RBITS (register address width), CNTBITS (stall counter
// width), DRAIN_CYCLES (cycles to empty EX/MEM/WB after HALT).
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int RBITS        = 5,
  parameter int CNTBITS      = 16,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  hazard_ctrl_if.slave  bus
);

  localparam int               DBITS      = drain_cnt_bits(DRAIN_CYCLES);
  localparam logic [DBITS-1:0] DRAIN_LOAD = DBITS'(DRAIN_CYCLES - 1);

  hz_state_t          state;
  hz_state_t          next_state;
  logic [DBITS-1:0]   drain_cnt;
  logic [DBITS-1:0]   drain_cnt_next;
  logic [CNTBITS-1:0] stall_cnt;
  logic               stall_inc;
  logic               halted;
  logic               load_use;
  logic               advance;
  logic               pc_write;
  logic               ifid_write;
  logic               ifid_flush;
  logic               idex_flush;
  logic               pipe_en;

  hazard_detect #(
    .RBITS(RBITS)
  ) u_detect (
    .ex_mem_read (bus.i_ex_mem_read),
    .ex_rt       (bus.i_ex_rt),
    .id_rs       (bus.i_id_rs),
    .id_rt       (bus.i_id_rt),
    .load_use    (load_use)
  );

  // In step mode the whole controller is frozen except on step pulses.
  always_comb begin
    advance = !bus.i_step_mode || bus.i_step;
  end

  // State register, drain counter, stall counter and registered halt flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
      halted    <= 1'b0;
    end else begin
      state     <= next_state;
      drain_cnt <= drain_cnt_next;
      halted    <= (next_state == HALTED);
      if (stall_inc && (stall_cnt != {CNTBITS{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  // Next-state and control outputs. Everything is forced quiet while reset
  // is asserted or when a stepped pipeline is not advancing. Branch wins over
  // load-use and HALT so wrong-path instructions are squashed, and a HALT
  // that also has a load-use hazard stalls first and is re-seen next cycle.
  always_comb begin
    next_state     = state;
    drain_cnt_next = drain_cnt;
    stall_inc      = 1'b0;
    pc_write       = 1'b0;
    ifid_write     = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    pipe_en        = 1'b0;
    if (i_rst_n && advance) begin
      case (state)
        RUN: begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          pipe_en    = 1'b1;
          if (bus.i_ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
          end else if (bus.i_id_halt) begin
            next_state     = DRAIN;
            drain_cnt_next = DRAIN_LOAD;
          end
        end
        DRAIN: begin
          idex_flush = 1'b1;
          pipe_en    = 1'b1;
          if (drain_cnt == '0) begin
            next_state = HALTED;
          end else begin
            drain_cnt_next = drain_cnt - 1'b1;
          end
        end
        HALTED: begin
          next_state = HALTED;
        end
        default: begin
          next_state = RUN;
        end
      endcase
    end
  end

  assign bus.o_pc_write   = pc_write;
  assign bus.o_ifid_write = ifid_write;
  assign bus.o_ifid_flush = ifid_flush;
  assign bus.o_idex_flush = idex_flush;
  assign bus.o_pipe_en    = pipe_en;
  assign bus.o_halted     = halted;
  assign bus.o_stall_cnt  = stall_cnt;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter RBITS, default 5, register-address width.
REQ-002 SHALL have parameter CNTBITS, default 16, stall-counter width.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 3, cycles to empty EX/MEM/WB after HALT.
REQ-004 i_clk  input  1  single clock; all state on rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_id_rs, i_id_rt  input  RBITS  source registers of instruction in ID.
REQ-007 i_ex_rt  input  RBITS  destination of instruction in EX.
REQ-008 i_ex_mem_read  input  1  EX instruction is a load.
REQ-009 i_ex_branch_taken  input  1  branch/jump resolved taken in EX.
REQ-010 i_id_halt  input  1  HALT opcode decoded in ID.
REQ-011 i_step_mode, i_step  input  1 each  debug single-step enable; one-cycle advance pulse.
REQ-012 o_pc_write, o_ifid_write  output  1 each  PC / IF-ID register enables.
REQ-013 o_ifid_flush, o_idex_flush  output  1 each  insert bubble into IF-ID / ID-EX.
REQ-014 o_pipe_en  output  1  global enable for ID-EX, EX-MEM, MEM-WB registers.
REQ-015 o_halted  output  1  pipeline drained and stopped.
REQ-016 o_stall_cnt  output  CNTBITS  saturating count of load-use stall cycles.

Function
REQ-017 FSM states SHALL be RUN, DRAIN, HALTED.
REQ-018 load_use SHALL be i_ex_mem_read & (i_ex_rt != 0) & (i_ex_rt == i_id_rs | i_ex_rt == i_id_rt), combinational.
REQ-019 advance SHALL be 1 when i_step_mode = 0, else equal to i_step; when advance = 0 all enables/flushes SHALL be 0 and no state, counter or flush SHALL change.
REQ-020 RUN, advance, no event: o_pc_write = o_ifid_write = o_pipe_en = 1, flushes 0.
REQ-021 RUN, advance, load_use, no branch: o_pc_write = o_ifid_write = 0, o_idex_flush = 1, o_pipe_en = 1, o_stall_cnt += 1 next edge (saturates at all-ones).
REQ-022 RUN, advance, i_ex_branch_taken: o_ifid_flush = o_idex_flush = 1, o_pc_write = o_ifid_write = o_pipe_en = 1; branch SHALL take priority over load_use and i_id_halt (no stall count).
REQ-023 RUN, advance, i_id_halt, no branch, no load_use: next state DRAIN, drain counter loaded with DRAIN_CYCLES-1; HALT itself proceeds to EX; load_use with halt SHALL stall first.
REQ-024 DRAIN: o_pc_write = o_ifid_write = 0, o_idex_flush = 1, o_pipe_en = advance; counter decrements per advancing cycle; at 0 with advance, next state HALTED.
REQ-025 HALTED: all enables and flushes 0, o_halted = 1; exit only by reset; inputs ignored.
REQ-026 o_halted SHALL be registered (asserts first cycle in HALTED); all other control outputs combinational from state and inputs.

Reset
REQ-027 i_rst_n low SHALL asynchronously force state RUN, drain counter 0, o_stall_cnt 0, o_halted 0, including mid-DRAIN or HALTED.
REQ-028 Combinational outputs during reset SHALL read o_pc_write = o_ifid_write = o_pipe_en = 0, flushes 0.
REQ-029 First rising edge after i_rst_n deasserts SHALL behave as RUN.

Structure
REQ-030 State encoding, DRAIN_CYCLES default and register-zero constant SHALL live in shared package mips_pkg.
REQ-031 load_use comparator SHALL be sub-module hazard_detect (combinational); FSM and counters in hazard_ctrl.

Verification
REQ-032 ex_mem_read=1, ex_rt=8, id_rs=8 -> one cycle pc_write=0, ifid_write=0, idex_flush=1; stall_cnt 0->1.
REQ-033 ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall; same with ex_branch_taken=1 and ex_rt=id_rt=9 -> both flushes 1, stall_cnt unchanged.
REQ-034 id_halt=1 one cycle -> pc_write=0 for 3 advancing cycles, o_halted=1 on 4th cycle and held 10 cycles despite stimulus.
REQ-035 step_mode=1, i_step pulses every 4 cycles during DRAIN -> o_halted after exactly 3 pulses; no output activity between pulses.
REQ-036 CNTBITS=4, 20 consecutive load-use cycles -> o_stall_cnt saturates at 15.
REQ-037 i_rst_n low mid-DRAIN and in HALTED -> immediately o_halted=0, stall_cnt=0; after release pipeline runs.
